// File: rtl/flash_boot_rec_ctrl.sv
// Boot-page record engine for the shared CFI flash: reads the stored page or
// rewrites it (clear status, unlock, erase, program, poll) and always leaves the part in read-array mode.
module flash_boot_rec_ctrl #(
  parameter logic [24:0] REC_ADDR = 25'h1FE0000,
  parameter int unsigned WAIT_CYC = 6,
  parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
  input  logic        clkin_50,
  input  logic        sys_reset,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [1:0]  wr_page,
  output logic [1:0]  page_out,
  output logic        rd_done,
  output logic        wr_done,
  output logic        busy,
  output logic        err,
  output logic [24:0] fc_fsm_a,
  output logic [15:0] fc_fsm_d_out,
  output logic        fc_fsm_d_oe,
  input  logic [15:0] fc_fsm_d_in,
  output logic        fc_flash_cen,
  output logic        fc_flash_oen,
  output logic        fc_flash_wen,
  output logic        fc_flash_advn
);

  localparam logic [3:0]  WAIT_LAST    = 4'(WAIT_CYC - 1);
  localparam logic [15:0] STAT_ERR_MSK = 16'h003A;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_RECOVER, ST_DONE
  } state_t;

  typedef enum logic [3:0] {
    CMD_CLR, CMD_UNLK1, CMD_UNLK2, CMD_ERS1, CMD_ERS2, CMD_PSTAT,
    CMD_PREAD, CMD_PGM1, CMD_PGM2, CMD_RDARR, CMD_RDREC
  } step_t;

  state_t      state_q, state_d;
  step_t       step_q, step_d;
  logic        op_rd_q, op_rd_d;
  logic        poll_pgm_q, poll_pgm_d;
  logic [3:0]  wait_q, wait_d;
  logic [23:0] poll_cnt_q, poll_cnt_d;
  logic [1:0]  page_q, page_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        err_d;
  logic [1:0]  page_out_d;
  logic        last_strobe, in_bus_d, is_wr_d;
  logic        cen_d, oen_d, wen_d, d_oe_d, rd_done_d, wr_done_d, busy_d;
  logic [15:0] d_out_d;
  logic [24:0] addr_d;

  function automatic logic [15:0] cmd_word(input step_t s, input logic [1:0] pg);
    case (s)
      CMD_CLR:   cmd_word = 16'h0050;
      CMD_UNLK1: cmd_word = 16'h0060;
      CMD_UNLK2: cmd_word = 16'h00D0;
      CMD_ERS1:  cmd_word = 16'h0020;
      CMD_ERS2:  cmd_word = 16'h00D0;
      CMD_PSTAT: cmd_word = 16'h0070;
      CMD_PGM1:  cmd_word = 16'h0040;
      CMD_PGM2:  cmd_word = {14'h3FFF, pg};
      CMD_RDARR: cmd_word = 16'h00FF;
      default:   cmd_word = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clkin_50) begin
    if (sys_reset) begin
      state_q       <= ST_IDLE;
      step_q        <= CMD_CLR;
      op_rd_q       <= 1'b0;
      poll_pgm_q    <= 1'b0;
      wait_q        <= 4'd0;
      poll_cnt_q    <= 24'd0;
      page_q        <= 2'b00;
      rd_data_q     <= 16'h0000;
      err           <= 1'b0;
      page_out      <= 2'b00;
      rd_done       <= 1'b0;
      wr_done       <= 1'b0;
      busy          <= 1'b0;
      fc_fsm_a      <= 25'd0;
      fc_fsm_d_out  <= 16'h0000;
      fc_fsm_d_oe   <= 1'b0;
      fc_flash_cen  <= 1'b1;
      fc_flash_oen  <= 1'b1;
      fc_flash_wen  <= 1'b1;
      fc_flash_advn <= 1'b1;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      op_rd_q       <= op_rd_d;
      poll_pgm_q    <= poll_pgm_d;
      wait_q        <= wait_d;
      poll_cnt_q    <= poll_cnt_d;
      page_q        <= page_d;
      rd_data_q     <= rd_data_d;
      err           <= err_d;
      page_out      <= page_out_d;
      rd_done       <= rd_done_d;
      wr_done       <= wr_done_d;
      busy          <= busy_d;
      fc_fsm_a      <= addr_d;
      fc_fsm_d_out  <= d_out_d;
      fc_fsm_d_oe   <= d_oe_d;
      fc_flash_cen  <= cen_d;
      fc_flash_oen  <= oen_d;
      fc_flash_wen  <= wen_d;
      fc_flash_advn <= advn_d();
    end
  end

  function automatic logic advn_d();
    advn_d = cen_d;
  endfunction

  // Sequencer: every command is one SETUP/STROBE/RECOVER bus cycle; the step
  // after each RECOVER decides what comes next, including poll exits.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    op_rd_d     = op_rd_q;
    poll_pgm_d  = poll_pgm_q;
    wait_d      = wait_q;
    poll_cnt_d  = poll_cnt_q;
    page_d      = page_q;
    rd_data_d   = rd_data_q;
    err_d       = err;
    page_out_d  = page_out;
    last_strobe = (state_q == ST_STROBE) && (wait_q == WAIT_LAST);

    if (last_strobe) begin
      rd_data_d = fc_fsm_d_in;
      if (step_q == CMD_RDREC)
        page_out_d = (fc_fsm_d_in[1:0] == 2'b11) ? 2'b00 : fc_fsm_d_in[1:0];
    end

    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          op_rd_d = 1'b1;
          step_d  = CMD_RDARR;
          err_d   = 1'b0;
          state_d = ST_SETUP;
        end else if (wr_req) begin
          op_rd_d = 1'b0;
          step_d  = CMD_CLR;
          page_d  = (wr_page == 2'b11) ? 2'b00 : wr_page;
          err_d   = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wait_d  = 4'd0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (last_strobe) state_d = ST_RECOVER;
        else             wait_d  = wait_q + 4'd1;
      end
      ST_RECOVER: begin
        state_d = ST_SETUP;
        case (step_q)
          CMD_CLR:   step_d = CMD_UNLK1;
          CMD_UNLK1: step_d = CMD_UNLK2;
          CMD_UNLK2: step_d = CMD_ERS1;
          CMD_ERS1:  step_d = CMD_ERS2;
          CMD_ERS2: begin
            step_d     = CMD_PSTAT;
            poll_pgm_d = 1'b0;
          end
          CMD_PSTAT: begin
            step_d     = CMD_PREAD;
            poll_cnt_d = 24'd0;
          end
          CMD_PREAD: begin
            // Any error bit or an exhausted poll budget abandons the rest of the rewrite.
            if (rd_data_q[7]) begin
              if ((rd_data_q & STAT_ERR_MSK) != 16'h0000) begin
                err_d  = 1'b1;
                step_d = CMD_RDARR;
              end else begin
                step_d = poll_pgm_q ? CMD_RDARR : CMD_PGM1;
              end
            end else if (poll_cnt_q == POLL_MAX - 24'd1) begin
              err_d  = 1'b1;
              step_d = CMD_RDARR;
            end else begin
              poll_cnt_d = poll_cnt_q + 24'd1;
            end
          end
          CMD_PGM1: step_d = CMD_PGM2;
          CMD_PGM2: begin
            step_d     = CMD_PSTAT;
            poll_pgm_d = 1'b1;
          end
          CMD_RDARR: begin
            if (op_rd_q) step_d  = CMD_RDREC;
            else         state_d = ST_DONE;
          end
          default: state_d = ST_DONE;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so the strobes leave flops cleanly.
  always_comb begin
    in_bus_d  = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_RECOVER);
    is_wr_d   = (step_d != CMD_PREAD) && (step_d != CMD_RDREC);
    cen_d     = (state_d != ST_STROBE);
    oen_d     = !((state_d == ST_STROBE) && !is_wr_d);
    wen_d     = !((state_d == ST_STROBE) && is_wr_d);
    d_oe_d    = in_bus_d && is_wr_d;
    d_out_d   = d_oe_d ? cmd_word(step_d, page_d) : 16'h0000;
    addr_d    = (state_d != ST_IDLE) ? REC_ADDR : fc_fsm_a;
    rd_done_d = (state_d == ST_DONE) && op_rd_d;
    wr_done_d = (state_d == ST_DONE) && !op_rd_d;
    busy_d    = (state_d != ST_IDLE);
  end

endmodule
